rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Round-robin arbiter that shares the register file's single write port between NUM_REQ writeback requesters (ALU, LSU, MUL/DIV). It sits between the execute/memory units and the register file.
- Each cycle it grants at most one valid request and registers the winner into a one-entry write stage that drives the register-file write port.
- It exposes a forwarding lookup so read-operand logic sees the staged write before it lands in the array.

## Interface
Parameters:
- DATA_WIDTH, 64, width of a register value
- NUM_REQ, 3, number of writeback requesters (2..8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  request i carries a write
- req_ready  out  NUM_REQ  request i is accepted this cycle
- req_addr  in  NUM_REQ*5  destination register of request i, bits [5i+4:5i]
- req_data  in  NUM_REQ*DATA_WIDTH  write value of request i, slice i
- stall  in  1  when high, no request is granted
- w_ena  out  1  register-file write enable
- w_addr  out  5  register-file write address
- w_data  out  DATA_WIDTH  register-file write data
- q_addr1, q_addr2  in  5  forwarding lookup addresses, one per read port
- q_hit1, q_hit2  out  1  staged write targets q_addrN
- q_data1, q_data2  out  DATA_WIDTH  forwarded value, zero when no hit
- grant_idx  out  $clog2(NUM_REQ)  index of the last accepted requester

## Operation
- State:
  - rr_ptr: priority pointer, $clog2(NUM_REQ) bits.
  - Write stage: w_ena, w_addr, w_data.
  - grant_idx.
- Arbitration (combinational):
  - When rst=0 and stall=0, scan i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins, and req_ready[i]=1.
  - All other ready bits are 0, so req_ready is one-hot or all-zero.
  - req_ready does not depend on the current w_ena. The write stage drains every cycle and never backpressures.
- Transfer: occurs on a clock edge where req_valid[i] & req_ready[i].
- On transfer of request g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - grant_idx <= g.
  - w_addr <= req_addr[g].
  - w_data <= req_data[g].
  - w_ena <= (req_addr[g] != 0).
  - A write to x0 is consumed (ready asserted) but produces no enable.
- No transfer: w_ena <= 0, and rr_ptr and grant_idx hold. w_addr and w_data hold their previous values.
- Requesters hold valid/addr/data stable until ready is seen. The arbiter does not check this.
- Forwarding (combinational):
  - q_hitN = w_ena & (w_addr == q_addrN) & (q_addrN != 0).
  - q_dataN = q_hitN ? w_data : 0.
- Reset:
  - w_ena=0, w_addr=0, w_data=0, rr_ptr=0, grant_idx=0.
  - req_ready=0 while rst=1.
  - q_hit=0 and q_data=0 after the reset edge.
  - A staged write present at reset is discarded.

## Timing
- Accept latency: req_ready is asserted in the same cycle as req_valid if the request wins.
- Write latency: a request accepted in cycle N drives w_* during cycle N+1 and is written into the array at the end of N+1.
- Forwarding covers cycle N+1. From N+2 onward the value is read from the array.
- Throughput: one write per cycle.
- Worst-case wait: a continuously valid requester waits at most NUM_REQ-1 cycles.
- Stall:
  - When stall=1 in cycle N, no ready is asserted and w_ena=0 in N+1.
  - A write already staged in cycle N still completes.
- Simultaneous events:
  - All requesters valid gives strict rotation 0,1,2,0,…
  - A request accepted while the same address is staged makes w_* take the new value next cycle. Last write wins.

## Test plan
- Reset:
  - Drive rst=1 for 2 cycles with all req_valid=1.
  - Expect req_ready=0, w_ena=0, w_addr=0, w_data=0, grant_idx=0.
- Rotation:
  - Hold NUM_REQ=3 all valid for 6 cycles with addrs 5/6/7 and data 0xA/0xB/0xC.
  - Expect grants 0,1,2,0,1,2.
  - Expect w_addr 5,6,7,… one cycle later, with w_ena=1 throughout.
- Single requester and x0:
  - Set req_valid=3'b010 with addr 0 and data 0xFF.
  - Expect req_ready=3'b010 and w_ena=0 next cycle.
  - Expect rr_ptr to advance to 2, so req 2 then wins a tie against req 0.
- Stall mid-stream:
  - Assert stall for 2 cycles with all valid.
  - Expect no ready in those cycles.
  - Expect the staged write from the preceding cycle to complete, followed by 2 cycles of w_ena=0.
  - After release, rotation resumes from the held rr_ptr.
- Forwarding:
  - Accept a write of addr 10, data 0x1234 in cycle N.
  - With q_addr1=10 and q_addr2=11 in N+1, expect q_hit1=1, q_data1=0x1234, q_hit2=0, q_data2=0.
  - In N+2 with no new request, expect q_hit1=0.
- Reset mid-operation:
  - Accept a write of addr 3 in cycle N and assert rst in N+1.
  - Expect w_ena=0 after the reset edge, and the register-file read of x3 to return 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the requesting units, the register-file write port and the
// operand forwarding lookup.
interface rf_wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 3
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*5-1:0]          req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          stall;
  logic                          w_ena;
  logic [4:0]                    w_addr;
  logic [DATA_WIDTH-1:0]         w_data;
  logic [4:0]                    q_addr1;
  logic [4:0]                    q_addr2;
  logic                          q_hit1;
  logic                          q_hit2;
  logic [DATA_WIDTH-1:0]         q_data1;
  logic [DATA_WIDTH-1:0]         q_data2;
  logic [IdxW-1:0]               grant_idx;

  // Environment side: requesters, stall source, register file and operand readers.
  modport master (
    output req_valid, req_addr, req_data, stall, q_addr1, q_addr2,
    input  req_ready, w_ena, w_addr, w_data, q_hit1, q_hit2, q_data1, q_data2, grant_idx
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_data, stall, q_addr1, q_addr2,
    output req_ready, w_ena, w_addr, w_data, q_hit1, q_hit2, q_data1, q_data2, grant_idx
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback units,
// with a one-entry write stage and forwarding lookup for the staged write.
module rf_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 3
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0]       rr_q, rr_d;
  logic [IdxW-1:0]       gnt_q, gnt_d;
  logic                  w_ena_q, w_ena_d;
  logic [4:0]            w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

  logic                  found;
  logic [IdxW-1:0]       win;
  logic [IdxW-1:0]       cand;
  logic [4:0]            win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Scan from rr_q upward (wrapping); first valid requester wins.
  always_comb begin
    found         = 1'b0;
    win           = '0;
    cand          = '0;
    bus.req_ready = '0;
    if (!rst && !bus.stall) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = IdxW'((32'(rr_q) + k) % NUM_REQ);
        if (!found && bus.req_valid[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
    bus.req_ready[win] = found;
  end

  assign win_addr = bus.req_addr[32'(win) * 5 +: 5];
  assign win_data = bus.req_data[32'(win) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_ena_d  = 1'b0;
    if (found) begin
      rr_d     = (win == IdxW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      gnt_d    = win;
      w_addr_d = win_addr;
      w_data_d = win_data;
      // x0 writes are consumed but never enabled.
      w_ena_d  = (win_addr != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      gnt_q    <= '0;
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign bus.w_ena     = w_ena_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;
  assign bus.grant_idx = gnt_q;

  assign bus.q_hit1  = w_ena_q && (w_addr_q == bus.q_addr1) && (bus.q_addr1 != 5'd0);
  assign bus.q_hit2  = w_ena_q && (w_addr_q == bus.q_addr2) && (bus.q_addr2 != 5'd0);
  assign bus.q_data1 = bus.q_hit1 ? w_data_q : '0;
  assign bus.q_data2 = bus.q_hit2 ? w_data_q : '0;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus queues expected grants and writes,
// a negedge monitor pops and compares them as the DUT presents ready / w_ena.
module tb_rf_wb_arbiter;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 3;

  typedef struct packed {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wr_t          wq[$];
  logic [NR-1:0] gq[$];
  logic [DW-1:0] rf[32];

  rf_wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  rf_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model; it is cleared by reset like the real array.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.w_ena === 1'b1 && bus.w_addr != 5'd0) begin
      rf[bus.w_addr] <= bus.w_data;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*5 +: 5]    = a;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic exp_grant(input int g);
    logic [NR-1:0] oh;
    oh = NR'(1) << g;
    gq.push_back(oh);
  endtask

  task automatic exp_write(input logic [4:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  // Monitor: every presented ready or write enable must match the next queued expectation.
  always @(negedge clk) begin
    logic [NR-1:0] eg;
    wr_t           ew;
    if (bus.req_ready !== '0) begin
      if (gq.size() == 0) begin
        chk("unexpected_ready", 64'(bus.req_ready), 64'd0);
      end else begin
        eg = gq.pop_front();
        chk("req_ready", 64'(bus.req_ready), 64'(eg));
      end
    end
    if (bus.w_ena === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_w_ena", 64'(bus.w_ena), 64'd0);
      end else begin
        ew = wq.pop_front();
        chk("w_addr", 64'(bus.w_addr), 64'(ew.addr));
        chk("w_data", bus.w_data, ew.data);
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.q_addr1   = 5'd10;
    bus.q_addr2   = 5'd11;
    set_req(0, 5'd5, 64'hA);
    set_req(1, 5'd6, 64'hB);
    set_req(2, 5'd7, 64'hC);

    // Reset held two cycles with all requesters valid
    step();
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_w_ena", 64'(bus.w_ena), 64'd0);
    chk("rst_w_addr", 64'(bus.w_addr), 64'd0);
    chk("rst_w_data", bus.w_data, 64'd0);
    chk("rst_grant_idx", 64'(bus.grant_idx), 64'd0);
    step();
    @(negedge clk);
    chk("rst2_ready", 64'(bus.req_ready), 64'd0);
    chk("rst2_w_ena", 64'(bus.w_ena), 64'd0);
    step();
    rst = 1'b0;

    // Strict rotation with everyone valid
    for (int c = 0; c < 6; c++) begin
      exp_grant(c % 3);
      exp_write(5'(5 + c % 3), 64'(10 + c % 3));
      @(negedge clk);
      if (c > 0) chk("rot_grant_idx", 64'(bus.grant_idx), 64'((c - 1) % 3));
      step();
    end

    // Single requester writing x0: consumed, no enable, pointer moves to 2
    bus.req_valid = 3'b010;
    set_req(1, 5'd0, 64'hFF);
    exp_grant(1);
    @(negedge clk);
    chk("rot_last_grant_idx", 64'(bus.grant_idx), 64'd2);
    step();
    bus.req_valid = 3'b101;
    exp_grant(2);
    exp_write(5'd7, 64'hC);
    @(negedge clk);
    chk("x0_w_ena", 64'(bus.w_ena), 64'd0);
    chk("x0_grant_idx", 64'(bus.grant_idx), 64'd1);
    chk("rf_x5", rf[5], 64'hA);
    chk("rf_x6", rf[6], 64'hB);
    chk("rf_x0", rf[0], 64'd0);
    step();
    exp_grant(0);
    exp_write(5'd5, 64'hA);
    @(negedge clk);
    chk("tie_grant_idx", 64'(bus.grant_idx), 64'd2);
    step();

    // Stall mid-stream: staged write completes, then two idle cycles
    bus.req_valid = 3'b111;
    set_req(1, 5'd6, 64'hB);
    exp_grant(1);
    exp_write(5'd6, 64'hB);
    @(negedge clk);
    step();
    bus.stall = 1'b1;
    @(negedge clk);
    chk("stall1_ready", 64'(bus.req_ready), 64'd0);
    step();
    @(negedge clk);
    chk("stall2_ready", 64'(bus.req_ready), 64'd0);
    chk("stall2_w_ena", 64'(bus.w_ena), 64'd0);
    step();
    bus.stall = 1'b0;
    exp_grant(2);
    exp_write(5'd7, 64'hC);
    @(negedge clk);
    chk("stall_rel_w_ena", 64'(bus.w_ena), 64'd0);
    chk("stall_rel_grant_idx", 64'(bus.grant_idx), 64'd1);
    step();

    // Forwarding of a staged write
    bus.req_valid = 3'b001;
    set_req(0, 5'd10, 64'h1234);
    exp_grant(0);
    exp_write(5'd10, 64'h1234);
    @(negedge clk);
    step();
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("fwd_hit1", 64'(bus.q_hit1), 64'd1);
    chk("fwd_data1", bus.q_data1, 64'h1234);
    chk("fwd_hit2", 64'(bus.q_hit2), 64'd0);
    chk("fwd_data2", bus.q_data2, 64'd0);
    step();
    @(negedge clk);
    chk("fwd_n2_hit1", 64'(bus.q_hit1), 64'd0);
    chk("fwd_n2_data1", bus.q_data1, 64'd0);
    chk("rf_x10", rf[10], 64'h1234);
    step();

    // Reset while a write to x3 is staged
    bus.req_valid = 3'b010;
    set_req(1, 5'd3, 64'h55);
    bus.q_addr1 = 5'd3;
    exp_grant(1);
    exp_write(5'd3, 64'h55);
    @(negedge clk);
    step();
    rst = 1'b1;
    bus.req_valid = 3'b111;
    @(negedge clk);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    step();
    @(negedge clk);
    chk("mid_rst_w_ena", 64'(bus.w_ena), 64'd0);
    chk("mid_rst_q_hit1", 64'(bus.q_hit1), 64'd0);
    chk("mid_rst_q_data1", bus.q_data1, 64'd0);
    chk("mid_rst_rf_x3", rf[3], 64'd0);
    chk("mid_rst_grant_idx", 64'(bus.grant_idx), 64'd0);
    step();
    rst = 1'b0;
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("write_queue_drained", 64'(wq.size()), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
